// File: rtl/adder_fault_scanner_pkg.sv
// adder_fault_scanner_pkg: FSM encodings and default operand width for the adder fault scanner
package adder_fault_scanner_pkg;
  localparam int DEF_WIDTH = 8;
  typedef enum logic [2:0] {S_IDLE, S_APPLY, S_WAIT, S_CHECK, S_DONE} state_t;
endpackage

// File: rtl/adder_fault_scanner_if.sv
// adder_fault_scanner_if: operand/result bus between the scanner and the adder under test
interface adder_fault_scanner_if import adder_fault_scanner_pkg::*; #(parameter int WIDTH = DEF_WIDTH);
  logic [WIDTH-1:0] dut_a;
  logic [WIDTH-1:0] dut_b;
  logic             dut_cin;
  logic [WIDTH:0]   dut_sum;
  modport master (output dut_a, dut_b, dut_cin, input dut_sum);
  modport slave (input dut_a, dut_b, dut_cin, output dut_sum);
endinterface

// File: rtl/adder_fault_scanner_golden.sv
// golden_adder: behavioural reference adder giving {cout,sum}
module golden_adder #(parameter int WIDTH = 8) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH:0]   o_sum
);
  assign o_sum = {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, i_cin};
endmodule

// File: rtl/adder_fault_scanner.sv
// adder_fault_scanner: sweeps every {A,B,CIN} through an external adder and records mismatches
module adder_fault_scanner import adder_fault_scanner_pkg::*; #(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int SETTLE_CYCLES = 2,
  parameter int COUNT_W       = 2*WIDTH+2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  adder_fault_scanner_if.master bus,
  output logic                  busy,
  output logic                  done,
  output logic [COUNT_W-1:0]    fail_count,
  output logic [WIDTH:0]        fault_mask,
  output logic                  first_fail_valid,
  output logic [WIDTH-1:0]      first_fail_a,
  output logic [WIDTH-1:0]      first_fail_b,
  output logic                  first_fail_cin,
  output logic [WIDTH:0]        first_fail_sum
);
  localparam int VW = 2*WIDTH+1;
  localparam int SW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SLOAD = SW'(SETTLE_CYCLES == 0 ? 0 : SETTLE_CYCLES-1);
  state_t r_state, w_state;
  logic [VW-1:0] r_vec, w_vec, r_ffvec, w_ffvec;
  logic [SW-1:0] r_settle, w_settle;
  logic [COUNT_W-1:0] r_fc, w_fc;
  logic [WIDTH:0] r_mask, w_mask, r_ffsum, w_ffsum, w_gold, w_diff;
  logic r_ffv, w_ffv, w_busy;
  golden_adder #(.WIDTH(WIDTH)) u_gold (
    .i_a(r_vec[VW-1 -: WIDTH]), .i_b(r_vec[WIDTH:1]), .i_cin(r_vec[0]), .o_sum(w_gold)
  );
  assign w_diff = bus.dut_sum ^ w_gold;
  assign w_busy = r_state == S_APPLY || r_state == S_WAIT || r_state == S_CHECK;
  always_comb begin
    w_state = r_state;
    w_vec = r_vec;
    w_settle = r_settle;
    w_fc = r_fc;
    w_mask = r_mask;
    w_ffv = r_ffv;
    w_ffvec = r_ffvec;
    w_ffsum = r_ffsum;
    case (r_state)
      S_IDLE, S_DONE: if (start) begin
        w_state = S_APPLY;
        w_vec = '0;
        w_fc = '0;
        w_mask = '0;
        w_ffv = 1'b0;
        w_ffvec = '0;
        w_ffsum = '0;
      end
      S_APPLY: begin
        w_settle = SLOAD;
        w_state = SETTLE_CYCLES == 0 ? S_CHECK : S_WAIT;
      end
      S_WAIT: begin
        w_settle = r_settle - 1'b1;
        w_state = r_settle == '0 ? S_CHECK : S_WAIT;
      end
      S_CHECK: begin
        if (w_diff != '0) begin
          w_fc = r_fc + COUNT_W'(r_fc != '1);
          w_mask = r_mask | w_diff;
          w_ffv = 1'b1;
          w_ffvec = r_ffv ? r_ffvec : r_vec;
          w_ffsum = r_ffv ? r_ffsum : bus.dut_sum;
        end
        w_state = &r_vec ? S_DONE : S_APPLY;
        w_vec = &r_vec ? r_vec : r_vec + 1'b1;
      end
      default: w_state = S_IDLE;
    endcase
    if (abort && w_busy) w_state = S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_vec <= '0;
      r_settle <= '0;
      r_fc <= '0;
      r_mask <= '0;
      r_ffv <= 1'b0;
      r_ffvec <= '0;
      r_ffsum <= '0;
    end else begin
      r_state <= w_state;
      r_vec <= w_vec;
      r_settle <= w_settle;
      r_fc <= w_fc;
      r_mask <= w_mask;
      r_ffv <= w_ffv;
      r_ffvec <= w_ffvec;
      r_ffsum <= w_ffsum;
    end
  end
  // operands are only presented while a sweep is active, so abort/idle leave the adder at zero
  assign bus.dut_a = w_busy ? r_vec[VW-1 -: WIDTH] : '0;
  assign bus.dut_b = w_busy ? r_vec[WIDTH:1] : '0;
  assign bus.dut_cin = w_busy & r_vec[0];
  assign busy = w_busy;
  assign done = r_state == S_DONE;
  assign fail_count = r_fc;
  assign fault_mask = r_mask;
  assign first_fail_valid = r_ffv;
  assign first_fail_a = r_ffvec[VW-1 -: WIDTH];
  assign first_fail_b = r_ffvec[WIDTH:1];
  assign first_fail_cin = r_ffvec[0];
  assign first_fail_sum = r_ffsum;
endmodule

// File: tb/tb_adder_fault_scanner.sv
// tb_adder_fault_scanner: scoreboarded sweeps of a fault-injectable adder (WIDTH=4 keeps runs short)
module tb_adder_fault_scanner;
  localparam int W = 4;
  localparam int NVEC = 1 << (2*W+1);
  localparam int CW = 2*W+2;
  typedef struct {int cyc; int fc; int mask; int ffv; int ffa; int ffb; int ffcin; int ffsum;} exp_t;
  logic clk = 0, rst = 1, start = 0, abort = 0, start0 = 0;
  int fm = 0, cyc = 0, n_chk = 0, n_fail = 0, t0 = 0;
  logic done_q = 0, done0_q = 0;
  exp_t q[$], q0[$], em, e0;
  logic busy, done, ffv, ffcin, busy0, done0, ffv0, ffcin0;
  logic [CW-1:0] fc, fc0;
  logic [W:0] mask, ffsum, mask0, ffsum0, s;
  logic [W-1:0] ffa, ffb, ffa0, ffb0;
  adder_fault_scanner_if #(.WIDTH(W)) bus ();
  adder_fault_scanner_if #(.WIDTH(W)) bus0 ();
  adder_fault_scanner #(.WIDTH(W), .SETTLE_CYCLES(2)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .bus(bus), .busy(busy), .done(done),
    .fail_count(fc), .fault_mask(mask), .first_fail_valid(ffv), .first_fail_a(ffa),
    .first_fail_b(ffb), .first_fail_cin(ffcin), .first_fail_sum(ffsum));
  adder_fault_scanner #(.WIDTH(W), .SETTLE_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .abort(1'b0), .bus(bus0), .busy(busy0), .done(done0),
    .fail_count(fc0), .fault_mask(mask0), .first_fail_valid(ffv0), .first_fail_a(ffa0),
    .first_fail_b(ffb0), .first_fail_cin(ffcin0), .first_fail_sum(ffsum0));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // adder under test: correct, SUM[2] stuck-at-0, or cout stuck-at-1
  always_comb begin
    s = {1'b0, bus.dut_a} + {1'b0, bus.dut_b} + {{W{1'b0}}, bus.dut_cin};
    bus.dut_sum = fm == 1 ? (s & ~(W+1)'(4)) : fm == 2 ? (s | (W+1)'(1 << W)) : s;
  end
  assign bus0.dut_sum = {1'b0, bus0.dut_a} + {1'b0, bus0.dut_b} + {{W{1'b0}}, bus0.dut_cin};
  task automatic chk(input string n, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  task automatic check_res(input exp_t e, input int c, fcv, mk, fv, a, b, ci, sm);
    chk("done_cycle", c, e.cyc);
    chk("fail_count", fcv, e.fc);
    chk("fault_mask", mk, e.mask);
    chk("first_fail_valid", fv, e.ffv);
    chk("first_fail_a", a, e.ffa);
    chk("first_fail_b", b, e.ffb);
    chk("first_fail_cin", ci, e.ffcin);
    chk("first_fail_sum", sm, e.ffsum);
  endtask
  always @(negedge clk) begin
    if (done && !done_q) begin
      if (q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        em = q.pop_front();
        check_res(em, cyc, int'(fc), int'(mask), int'(ffv), int'(ffa), int'(ffb), int'(ffcin), int'(ffsum));
      end
    end
    if (done0 && !done0_q) begin
      if (q0.size() == 0) chk("unexpected_done0", 1, 0);
      else begin
        e0 = q0.pop_front();
        check_res(e0, cyc, int'(fc0), int'(mask0), int'(ffv0), int'(ffa0), int'(ffb0), int'(ffcin0), int'(ffsum0));
      end
    end
    done_q = done;
    done0_q = done0;
  end
  task automatic pulse_start(input int f);
    @(negedge clk);
    fm = f;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    t0 = cyc;
  endtask
  task automatic wait_done(input string n);
    int i;
    for (i = 0; i < 4*NVEC + 50 && !done; i++) @(negedge clk);
    if (!done) chk({n, "_timeout"}, 0, 1);
  endtask
  task automatic sweep(input int f, input exp_t e);
    pulse_start(f);
    e.cyc = t0 + 4*NVEC;
    q.push_back(e);
    wait_done("sweep");
  endtask
  task automatic chk_zero(input string n);
    chk({n, "_busy"}, int'(busy), 0);
    chk({n, "_done"}, int'(done), 0);
    chk({n, "_dut_a"}, int'(bus.dut_a), 0);
    chk({n, "_dut_b"}, int'(bus.dut_b), 0);
    chk({n, "_dut_cin"}, int'(bus.dut_cin), 0);
  endtask
  initial begin
    int i;
    exp_t ok, f2, f8;
    ok = '{0, 0, 0, 0, 0, 0, 0, 0};
    f2 = '{0, NVEC/2, 4, 1, 0, 3, 1, 0};
    f8 = '{0, NVEC/2, 1 << W, 1, 0, 0, 0, 1 << W};
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk_zero("reset");
    chk("reset_fail_count", int'(fc), 0);
    chk("reset_fault_mask", int'(mask), 0);
    chk("reset_ffv", int'(ffv), 0);
    @(negedge clk);
    start0 = 1;
    @(posedge clk);
    #1 start0 = 0;
    e0 = ok;
    e0.cyc = cyc + 2*NVEC;
    q0.push_back(e0);
    for (i = 0; i < 2*NVEC + 50 && !done0; i++) @(negedge clk);
    if (!done0) chk("settle0_timeout", 0, 1);
    sweep(0, ok);
    sweep(1, f2);
    sweep(2, f8);
    pulse_start(1);
    repeat (99) @(negedge clk);
    abort = 1;
    @(posedge clk);
    #1 abort = 0;
    @(negedge clk);
    chk_zero("abort");
    chk("abort_kept_mask", int'(mask), 4);
    chk("abort_kept_ffv", int'(ffv), 1);
    chk("abort_kept_ffb", int'(ffb), 3);
    pulse_start(0);
    ok.cyc = t0 + 4*NVEC;
    q.push_back(ok);
    repeat (50) @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    wait_done("midstart");
    pulse_start(1);
    repeat (300) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk_zero("midrst");
    chk("midrst_fail_count", int'(fc), 0);
    chk("midrst_fault_mask", int'(mask), 0);
    chk("midrst_ffv", int'(ffv), 0);
    chk("midrst_ffsum", int'(ffsum), 0);
    sweep(1, f2);
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", q.size() + q0.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
